// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - pc_sequencer state encoding, pc_sel codes and PC step.
package pc_seq_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_UPDATE = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_BRZ = 2'b01;
   localparam logic [1:0] PC_SEL_JMP = 2'b10;
   localparam logic [1:0] PC_SEL_JR  = 2'b11;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC selection and misaligned-target flag.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] pc,
   input  logic [1:0]        pc_sel,
   input  logic              zero,
   input  logic [DATA_W-1:0] br_target,
   input  logic [DATA_W-1:0] j_target,
   input  logic [DATA_W-1:0] jr_target,
   output logic [DATA_W-1:0] next_pc,
   output logic              misalign
);

   logic [DATA_W-1:0] seq_pc;
   logic [DATA_W-1:0] tgt;
   logic              taken;

   always_comb begin
      seq_pc = pc + DATA_W'(PC_STEP);
      taken  = 1'b1;
      tgt    = jr_target;
      case (pc_sel)
         PC_SEL_SEQ: taken = 1'b0;
         PC_SEL_BRZ: begin
            taken = zero;
            tgt   = br_target;
         end
         PC_SEL_JMP: tgt = j_target;
         default:    tgt = jr_target;
      endcase
      // An untaken branch never flags misalign, whatever its target bits.
      next_pc  = taken ? {tgt[DATA_W-1:2], 2'b00} : seq_pc;
      misalign = taken & (|tgt[1:0]);
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - FETCH/EXEC/UPDATE sequencer owning the program counter.
// Optional PC_SEQ_RETIRE_CNT_EN adds the retire_cnt output.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic              ex_done,
   input  logic [1:0]        pc_sel,
   input  logic              zero,
   input  logic              is_halt,
   input  logic [DATA_W-1:0] br_target,
   input  logic [DATA_W-1:0] j_target,
   input  logic [DATA_W-1:0] jr_target,
   output logic [DATA_W-1:0] pc,
   output logic              pc_we,
   output logic              misalign,
   output logic              busy,
   output logic              halted
`ifdef PC_SEQ_RETIRE_CNT_EN
   ,
   output logic [31:0]       retire_cnt
`endif
);

   logic [2:0]        state;
   logic [1:0]        s_sel;
   logic              s_zero;
   logic [DATA_W-1:0] s_br;
   logic [DATA_W-1:0] s_j;
   logic [DATA_W-1:0] s_jr;
   logic [DATA_W-1:0] next_pc;
   logic              next_mis;

   pc_next_sel #(.DATA_W(DATA_W)) u_next (
      .pc        (pc),
      .pc_sel    (s_sel),
      .zero      (s_zero),
      .br_target (s_br),
      .j_target  (s_j),
      .jr_target (s_jr),
      .next_pc   (next_pc),
      .misalign  (next_mis)
   );

   // Outputs depend only on state and sampled registers, never on live inputs.
   assign imem_req = (state == ST_FETCH);
   assign pc_we    = (state == ST_UPDATE);
   assign misalign = pc_we & next_mis;
   assign halted   = (state == ST_HALT);
   assign busy     = (state != ST_IDLE) && (state != ST_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pc     <= RESET_PC;
         s_sel  <= PC_SEL_SEQ;
         s_zero <= 1'b0;
         s_br   <= '0;
         s_j    <= '0;
         s_jr   <= '0;
      end else begin
         case (state)
            ST_IDLE:  if (start) state <= ST_FETCH;
            ST_FETCH: if (imem_ack) state <= ST_EXEC;
            ST_EXEC: begin
               if (ex_done) begin
                  s_sel  <= pc_sel;
                  s_zero <= zero;
                  s_br   <= br_target;
                  s_j    <= j_target;
                  s_jr   <= jr_target;
                  state  <= is_halt ? ST_HALT : ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               pc    <= next_pc;
               state <= ST_FETCH;
            end
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

`ifdef PC_SEQ_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if ((state == ST_UPDATE) || ((state == ST_EXEC) && ex_done && is_halt)) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule
